// File: rtl/mux_gate_checker_if.sv
// Stimulus/response bundle between mux_gate_checker and the gate set under test.
// The checker is the slave; the gate network plus run controller is the master.
interface mux_gate_checker_if #(
    parameter int ERR_W = 8
);
    logic             start;
    logic             a;
    logic             b;
    logic [6:0]       x;
    logic             busy;
    logic             done;
    logic             pass;
    logic [ERR_W-1:0] err_count;
    logic [6:0]       fail_vec;

    modport master (
        output start, x,
        input  a, b, busy, done, pass, err_count, fail_vec
    );

    modport slave (
        input  start, x,
        output a, b, busy, done, pass, err_count, fail_vec
    );
endinterface

// File: rtl/mux_gate_checker.sv
// Sweeps {a,b} through all four vectors, compares the seven gate outputs
// against their truth table and reports sticky fail flags and an error count.
module mux_gate_checker #(
    parameter int SETTLE = 2,
    parameter int PASSES = 1,
    parameter int ERR_W  = 8
) (
    input logic              clk,
    input logic              rst,
    mux_gate_checker_if.slave bus
);
    localparam int CW  = (SETTLE > 1) ? $clog2(SETTLE) : 1;
    localparam int PW  = (PASSES > 1) ? $clog2(PASSES) : 1;
    localparam int EW1 = ERR_W + 1;

    typedef enum logic [1:0] {
        S_IDLE,
        S_SETTLE,
        S_CHECK,
        S_DONE
    } state_t;

    state_t           state;
    logic [1:0]       idx;
    logic [CW-1:0]    cnt;
    logic [PW-1:0]    pcnt;
    logic             a_q;
    logic             b_q;
    logic             busy_q;
    logic             done_q;
    logic             pass_q;
    logic [ERR_W-1:0] err_q;
    logic [6:0]       fail_q;

    logic [6:0]       e;
    logic [6:0]       m;
    logic [2:0]       pop;
    logic [ERR_W:0]   sum;
    logic [ERR_W-1:0] err_nxt;
    logic             last_vec;

    assign e = {~(a_q ^ b_q), ~a_q, a_q ^ b_q, ~(a_q | b_q),
                ~(a_q & b_q), a_q | b_q, a_q & b_q};
    assign m = bus.x ^ e;

    always_comb begin
        pop = '0;
        for (int i = 0; i < 7; i++) begin
            pop = pop + 3'(m[i]);
        end
    end

    // Widen before adding so an overflow is seen and clamps instead of wrapping.
    assign sum      = {1'b0, err_q} + EW1'(pop);
    assign err_nxt  = sum[ERR_W] ? {ERR_W{1'b1}} : sum[ERR_W-1:0];
    assign last_vec = (idx == 2'd3) && (pcnt == PW'(PASSES - 1));

    always_ff @(posedge clk) begin
        if (rst) begin
            state  <= S_IDLE;
            idx    <= '0;
            cnt    <= '0;
            pcnt   <= '0;
            a_q    <= 1'b0;
            b_q    <= 1'b0;
            busy_q <= 1'b0;
            done_q <= 1'b0;
            pass_q <= 1'b0;
            err_q  <= '0;
            fail_q <= '0;
        end else begin
            unique case (state)
                S_IDLE, S_DONE: begin
                    if (bus.start) begin
                        state  <= S_SETTLE;
                        idx    <= '0;
                        cnt    <= '0;
                        pcnt   <= '0;
                        a_q    <= 1'b0;
                        b_q    <= 1'b0;
                        busy_q <= 1'b1;
                        done_q <= 1'b0;
                        pass_q <= 1'b0;
                        err_q  <= '0;
                        fail_q <= '0;
                    end
                end
                S_SETTLE: begin
                    if (cnt == CW'(SETTLE - 1)) begin
                        state <= S_CHECK;
                    end else begin
                        cnt <= cnt + CW'(1);
                    end
                end
                S_CHECK: begin
                    fail_q <= fail_q | m;
                    err_q  <= err_nxt;
                    if (last_vec) begin
                        state  <= S_DONE;
                        busy_q <= 1'b0;
                        done_q <= 1'b1;
                        pass_q <= (err_nxt == '0);
                    end else begin
                        state        <= S_SETTLE;
                        cnt          <= '0;
                        idx          <= idx + 2'd1;
                        {a_q, b_q}   <= idx + 2'd1;
                        if (idx == 2'd3) begin
                            pcnt <= pcnt + PW'(1);
                        end
                    end
                end
            endcase
        end
    end

    assign bus.a         = a_q;
    assign bus.b         = b_q;
    assign bus.busy      = busy_q;
    assign bus.done      = done_q;
    assign bus.pass      = pass_q;
    assign bus.err_count = err_q;
    assign bus.fail_vec  = fail_q;
endmodule

// File: doc/mux_gate_checker.md
Name: mux_gate_checker

Overview:
- Self-checking stimulus/response stage for the 2:1-mux gate library (and, or, nand, nor, xor, not, xnor).
- Upstream, it drives the shared gate inputs a, b through all four {a,b} combinations.
- Downstream, it samples the seven gate outputs, compares them against the golden truth table, and reports per-gate fail flags, an error count and a pass/done status.
- Synthesizable, so the gate set can be checked on silicon or FPGA as well as in simulation.

Parameters:
- SETTLE, 2: cycles a/b are held before outputs are sampled; legal range is 1 or more.
- PASSES, 1: number of full 4-vector sweeps per run; legal range is 1 or more.
- ERR_W, 8: width of err_count.

Ports:
- clk, input, 1: rising-edge clock.
- rst, input, 1: synchronous, active-high reset.
- start, input, 1: single-cycle run request.
- a, output, 1: gate input a.
- b, output, 1: gate input b.
- x, input, 7: gate outputs. x[0]=and, x[1]=or, x[2]=nand, x[3]=nor, x[4]=xor, x[5]=not(a), x[6]=xnor.
- busy, output, 1: run in progress.
- done, output, 1: run complete; sticky until the next start or rst.
- pass, output, 1: done with zero errors.
- err_count, output, ERR_W: number of mismatching bits, saturating.
- fail_vec, output, 7: sticky per-gate mismatch flag, bit order as for x.

Behaviour:
- Reset:
  - Clock is clk; reset is rst, synchronous and active-high, sampled on the rising edge of clk.
  - On reset: state=IDLE; a=0, b=0, busy=0, done=0, pass=0, err_count=0, fail_vec=0.
  - Internal vector index, pass counter and settle counter are also cleared.
  - rst asserted mid-run aborts the run; all outputs hold reset values from the next edge.
- States: IDLE, SETTLE, CHECK, DONE.
- IDLE:
  - start=1 moves to SETTLE.
  - Clears err_count, fail_vec, done and pass.
  - Sets idx=0, {a,b}=2'b00, busy=1.
- SETTLE:
  - Holds a/b steady for exactly SETTLE cycles (counter 0..SETTLE-1), then goes to CHECK.
- CHECK (one cycle):
  - Expected values per bit: e[0]=a&b, e[1]=a|b, e[2]=~(a&b), e[3]=~(a|b), e[4]=a^b, e[5]=~a, e[6]=~(a^b).
  - Mismatch mask m = x ^ e.
  - fail_vec |= m.
  - err_count += popcount(m), saturating at 2^ERR_W-1 with no wrap.
  - If idx=3 and the pass counter is PASSES-1: go to DONE.
  - Otherwise idx=idx+1 (wrapping 3 to 0 and incrementing the pass counter), drive {a,b}=new idx, return to SETTLE.
- DONE:
  - busy=0, done=1.
  - pass=1 iff err_count==0 (registered; valid in the same cycle done rises).
  - a/b hold their last value (2'b11).
  - start=1 in DONE begins a new run exactly as from IDLE: counters cleared, done and pass drop the next cycle.
- start handling:
  - start is ignored while busy=1.
  - start and rst asserted together: rst wins.
- Timing:
  - a/b change only on the edge that enters SETTLE.
  - x is sampled only in CHECK, so the gate network gets SETTLE full cycles of settling.
  - Latency from the edge sampling start to done=1 is 1 + 4*PASSES*(SETTLE+1) edges. Defaults give 13.
  - Each vector occupies SETTLE+1 cycles.
- Widths:
  - popcount is 3 bits (max 7).
  - The addition is done at ERR_W+1 bits before saturation.

Test Plan:
- Correct gate models connected, defaults: pulse start → a/b sequence 00,01,10,11 with each value held 3 cycles; done=1 at edge 13; pass=1; err_count=0; fail_vec=0.
- xor output stuck at 0 (x[4]=0): run → err_count=2 (vectors 01 and 10), fail_vec=7'b0010000, pass=0.
- All seven outputs inverted, PASSES=10, ERR_W=8: 28 errors per pass, 280 total → err_count saturates at 255, fail_vec=7'h7F, pass=0.
- PASSES=2, and output stuck at 1 (x[0]=1): err_count=6 (3 errors per pass), fail_vec=7'b0000001; done at edge 1+8*3=25.
- rst asserted during the 2nd vector's SETTLE → next cycle busy=0, a=b=0, err_count=0, state IDLE. Then start → a full clean run completes normally.
- start re-pulsed while busy → ignored, and done timing is unchanged. start pulsed in DONE after a failing run → err_count and fail_vec clear, done and pass drop the next cycle, and the new run completes.
